// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one access at a time onto a valid/ready data bus, with lane alignment and load write-back.
// Latency: zero-wait load takes 4 cycles (detect, REQ, WAIT_R, DONE); a store takes 3; a misaligned access takes 2.
// Backpressure: pause holds the pipeline until DONE; bus_valid and its payload stay stable until bus_ready or timeout.
module mem_access_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      load_mode,
    input  logic [XLEN-1:0] load_addr,
    input  logic [4:0]      load_regs_addr,
    input  logic [1:0]      store_mode,
    input  logic [XLEN-1:0] store_addr,
    input  logic [XLEN-1:0] store_data,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic [3:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            pause,
    output logic            regs_write_en,
    output logic [4:0]      regs_write_addr,
    output logic [XLEN-1:0] regs_write_data,
    output logic            fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } state_t;

    typedef struct packed {
        logic            is_store;
        logic [XLEN-1:0] addr;
        logic [2:0]      load_mode;
        logic [4:0]      rd;
        logic [3:0]      wstrb;
        logic [XLEN-1:0] wdata;
    } req_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    req_t            req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            store_req;
    logic            load_req;
    logic            req_present;
    logic            misaligned;
    logic            timeout_hit;
    logic [3:0]      new_wstrb;
    logic [XLEN-1:0] new_wdata;
    logic [XLEN-1:0] load_shifted;
    logic [XLEN-1:0] load_ext;

    assign store_req   = (store_mode != 2'b00);
    assign load_req    = (load_mode != 3'b111);
    assign req_present = !rst && (store_req || load_req);
    assign timeout_hit = (cnt_q == TO_LAST);

    // Lane placement and alignment check for the incoming request (store takes priority).
    always_comb begin
        new_wstrb  = 4'b1111;
        new_wdata  = store_data;
        misaligned = 1'b0;
        if (store_req) begin
            case (store_mode)
                2'b01: begin
                    new_wstrb = 4'b0001 << store_addr[1:0];
                    new_wdata = {(XLEN/8){store_data[7:0]}};
                end
                2'b10: begin
                    new_wstrb  = 4'b0011 << store_addr[1:0];
                    new_wdata  = {(XLEN/16){store_data[15:0]}};
                    misaligned = store_addr[0];
                end
                default: begin
                    new_wstrb  = 4'b1111;
                    new_wdata  = store_data;
                    misaligned = (store_addr[1:0] != 2'b00);
                end
            endcase
        end else begin
            case (load_mode)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = load_addr[0];
                default:        misaligned = (load_addr[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        pause   = 1'b0;
        case (state_q)
            S_IDLE: begin
                fault_d = 1'b0;
                if (req_present) begin
                    pause           = 1'b1;
                    req_d.is_store  = store_req;
                    req_d.addr      = store_req ? store_addr : load_addr;
                    req_d.load_mode = load_mode;
                    req_d.rd        = load_regs_addr;
                    req_d.wstrb     = new_wstrb;
                    req_d.wdata     = new_wdata;
                    cnt_d           = 8'd0;
                    if (misaligned) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                pause = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (bus_ready) begin
                    state_d = req_q.is_store ? S_DONE : S_WAIT_R;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end
            end
            S_WAIT_R: begin
                pause = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load data is extracted from the latched word during DONE.
    always_comb begin
        load_shifted = rdata_q >> {req_q.addr[1:0], 3'b000};
        case (req_q.load_mode)
            3'b000:  load_ext = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
            default: load_ext = rdata_q;
        endcase
    end

    always_comb begin
        bus_valid       = (state_q == S_REQ);
        bus_addr        = bus_valid ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
        bus_we          = bus_valid & req_q.is_store;
        bus_wstrb       = bus_valid ? req_q.wstrb : 4'b0000;
        bus_wdata       = bus_valid ? req_q.wdata : '0;
        fault           = (state_q == S_DONE) & fault_q;
        regs_write_en   = (state_q == S_DONE) & !fault_q & !req_q.is_store & (req_q.rd != 5'd0);
        regs_write_addr = regs_write_en ? req_q.rd : 5'd0;
        regs_write_data = regs_write_en ? load_ext : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a default-TIMEOUT instance for alignment, extension, stalls and reset,
// plus a TIMEOUT=4 instance with its own reset and bus handshakes for the timeout paths.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst, to_rst;
    logic [2:0]  load_mode;
    logic [31:0] load_addr;
    logic [4:0]  load_regs_addr;
    logic [1:0]  store_mode;
    logic [31:0] store_addr, store_data;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        to_ready, to_rvalid;

    logic        bus_valid, bus_we, pause, regs_write_en, fault;
    logic [31:0] bus_addr, bus_wdata, regs_write_data;
    logic [3:0]  bus_wstrb;
    logic [4:0]  regs_write_addr;

    logic        to_valid, to_we, to_pause, to_wen, to_fault;
    logic [31:0] to_addr, to_wdata, to_wrdata;
    logic [3:0]  to_wstrb;
    logic [4:0]  to_waddr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst(rst),
        .load_mode(load_mode), .load_addr(load_addr), .load_regs_addr(load_regs_addr),
        .store_mode(store_mode), .store_addr(store_addr), .store_data(store_data),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .pause(pause), .regs_write_en(regs_write_en), .regs_write_addr(regs_write_addr),
        .regs_write_data(regs_write_data), .fault(fault)
    );

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(4)) u_to (
        .clk(clk), .rst(to_rst),
        .load_mode(load_mode), .load_addr(load_addr), .load_regs_addr(load_regs_addr),
        .store_mode(store_mode), .store_addr(store_addr), .store_data(store_data),
        .bus_valid(to_valid), .bus_ready(to_ready), .bus_addr(to_addr), .bus_we(to_we),
        .bus_wstrb(to_wstrb), .bus_wdata(to_wdata), .bus_rvalid(to_rvalid), .bus_rdata(bus_rdata),
        .pause(to_pause), .regs_write_en(to_wen), .regs_write_addr(to_waddr),
        .regs_write_data(to_wrdata), .fault(to_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic no_req();
        load_mode      = 3'b111;
        load_addr      = 32'h0;
        load_regs_addr = 5'd0;
        store_mode     = 2'b00;
        store_addr     = 32'h0;
        store_data     = 32'h0;
    endtask

    task automatic do_load(input logic [2:0] mode, input logic [31:0] addr, input logic [4:0] rd);
        load_mode      = mode;
        load_addr      = addr;
        load_regs_addr = rd;
    endtask

    task automatic do_store(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] data);
        store_mode = mode;
        store_addr = addr;
        store_data = data;
    endtask

    initial begin
        rst = 1'b1; to_rst = 1'b1;
        no_req();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        to_ready = 1'b0; to_rvalid = 1'b0;
        tick(); tick(); #1;
        chk("rst_pause", pause, 0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_wen", regs_write_en, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_to_pause", to_pause, 0);
        tick(); rst = 1'b0; #1;
        chk("idle_pause", pause, 0);

        // SW, zero-wait bus
        tick(); do_store(2'b11, 32'h100, 32'hDEADBEEF); bus_ready = 1'b1; #1;
        chk("sw_detect_pause", pause, 1);
        chk("sw_detect_valid", bus_valid, 0);
        tick(); #1;
        chk("sw_req_valid", bus_valid, 1);
        chk("sw_req_addr", bus_addr, 32'h100);
        chk("sw_req_we", bus_we, 1);
        chk("sw_req_wstrb", bus_wstrb, 4'hF);
        chk("sw_req_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_req_pause", pause, 1);
        tick(); no_req(); #1;
        chk("sw_done_pause", pause, 0);
        chk("sw_done_wen", regs_write_en, 0);
        chk("sw_done_fault", fault, 0);
        chk("sw_done_valid", bus_valid, 0);

        // SB to lane 3
        tick(); do_store(2'b01, 32'h203, 32'h000000A5); #1;
        chk("sb_detect_pause", pause, 1);
        tick(); #1;
        chk("sb_wstrb", bus_wstrb, 4'b1000);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        chk("sb_addr", bus_addr, 32'h200);
        tick(); no_req(); #1;
        chk("sb_done_fault", fault, 0);

        // SH to upper half
        tick(); do_store(2'b10, 32'h12, 32'h0000BEEF);
        tick(); #1;
        chk("sh_wstrb", bus_wstrb, 4'b1100);
        chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
        chk("sh_addr", bus_addr, 32'h10);
        tick(); no_req();

        // store and load together: store wins
        tick(); do_store(2'b11, 32'h20, 32'h55); do_load(3'b000, 32'h30, 5'd4);
        tick(); #1;
        chk("both_we", bus_we, 1);
        chk("both_addr", bus_addr, 32'h20);
        tick(); no_req(); #1;
        chk("both_wen", regs_write_en, 0);

        // LB; rvalid alongside ready must be ignored
        tick(); do_load(3'b000, 32'h41, 5'd5); #1;
        chk("lb_detect_pause", pause, 1);
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'h12345678; #1;
        chk("lb_req_valid", bus_valid, 1);
        chk("lb_req_we", bus_we, 0);
        chk("lb_req_addr", bus_addr, 32'h40);
        tick(); bus_rdata = 32'h0000F000; #1;
        chk("lb_waitr_pause", pause, 1);
        chk("lb_waitr_valid", bus_valid, 0);
        chk("lb_waitr_wen", regs_write_en, 0);
        tick(); no_req(); bus_rvalid = 1'b0; #1;
        chk("lb_wen", regs_write_en, 1);
        chk("lb_waddr", regs_write_addr, 5);
        chk("lb_wdata", regs_write_data, 32'hFFFFFFF0);
        chk("lb_done_pause", pause, 0);

        // LBU
        tick(); do_load(3'b100, 32'h41, 5'd5);
        tick();
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'h0000F000;
        tick(); no_req(); bus_rvalid = 1'b0; #1;
        chk("lbu_wen", regs_write_en, 1);
        chk("lbu_wdata", regs_write_data, 32'h000000F0);

        // LH upper half
        tick(); do_load(3'b001, 32'h42, 5'd6);
        tick();
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'h80011234;
        tick(); no_req(); bus_rvalid = 1'b0; #1;
        chk("lh_wdata", regs_write_data, 32'hFFFF8001);
        chk("lh_waddr", regs_write_addr, 6);

        // misaligned LW
        tick(); do_load(3'b010, 32'h06, 5'd8); #1;
        chk("mis_detect_pause", pause, 1);
        chk("mis_detect_valid", bus_valid, 0);
        tick(); no_req(); #1;
        chk("mis_fault", fault, 1);
        chk("mis_valid", bus_valid, 0);
        chk("mis_wen", regs_write_en, 0);
        chk("mis_pause", pause, 0);
        tick(); #1;
        chk("mis_after_fault", fault, 0);
        chk("mis_after_pause", pause, 0);

        // LW with ready low for 3 cycles, rvalid after 2 idle WAIT_R cycles
        tick(); do_load(3'b010, 32'h80, 5'd7); bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); if (i == 3) bus_ready = 1'b1; #1;
            chk("stall_req_valid", bus_valid, 1);
            chk("stall_req_addr", bus_addr, 32'h80);
            chk("stall_req_pause", pause, 1);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("stall_waitr_pause", pause, 1);
            chk("stall_waitr_valid", bus_valid, 0);
        end
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
        chk("stall_last_pause", pause, 1);
        tick(); no_req(); bus_rvalid = 1'b0; #1;
        chk("stall_wen", regs_write_en, 1);
        chk("stall_waddr", regs_write_addr, 7);
        chk("stall_wdata", regs_write_data, 32'hCAFEF00D);

        // TIMEOUT=4 instance: rvalid never arrives
        tick(); rst = 1'b1; to_rst = 1'b0;
        tick(); do_load(3'b010, 32'h90, 5'd3); to_ready = 1'b1; to_rvalid = 1'b0; #1;
        chk("to_detect_pause", to_pause, 1);
        tick(); #1;
        chk("to_req_valid", to_valid, 1);
        tick(); #1;
        chk("to_w1_pause", to_pause, 1);
        chk("to_w1_valid", to_valid, 0);
        tick();
        tick(); #1;
        chk("to_w3_fault", to_fault, 0);
        chk("to_w3_pause", to_pause, 1);
        tick(); no_req(); #1;
        chk("to_fault", to_fault, 1);
        chk("to_wen", to_wen, 0);
        chk("to_done_pause", to_pause, 0);
        tick(); #1;
        chk("to_idle_fault", to_fault, 0);
        chk("to_idle_pause", to_pause, 0);

        // TIMEOUT=4 instance: ready never arrives
        tick(); do_store(2'b11, 32'hA0, 32'h1); to_ready = 1'b0;
        tick(); #1;
        chk("toreq_c0_valid", to_valid, 1);
        tick();
        tick();
        tick(); #1;
        chk("toreq_c3_valid", to_valid, 1);
        tick(); no_req(); #1;
        chk("toreq_fault", to_fault, 1);
        chk("toreq_valid", to_valid, 0);
        tick(); #1;
        chk("toreq_idle_pause", to_pause, 0);

        // reset while in WAIT_R
        tick(); to_rst = 1'b1; rst = 1'b0;
        tick(); do_load(3'b010, 32'h44, 5'd9); bus_ready = 1'b1; bus_rvalid = 1'b0;
        tick();
        tick(); #1;
        chk("rstw_waitr_pause", pause, 1);
        rst = 1'b1; no_req();
        tick(); rst = 1'b0; #1;
        chk("rstw_pause", pause, 0);
        chk("rstw_valid", bus_valid, 0);
        chk("rstw_wen", regs_write_en, 0);
        chk("rstw_fault", fault, 0);
        tick(); #1;
        chk("rstw_after_wen", regs_write_en, 0);
        chk("rstw_after_pause", pause, 0);

        // load to x0 completes without a write
        tick(); do_load(3'b010, 32'h48, 5'd0);
        tick();
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
        tick(); no_req(); bus_rvalid = 1'b0; #1;
        chk("x0_wen", regs_write_en, 0);
        chk("x0_fault", fault, 0);
        chk("x0_pause", pause, 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
